// File: rtl/inst_bus_responder_pkg.sv
// Shared constants, FSM encoding and helpers for the instruction bus responder.
package inst_bus_responder_pkg;

    localparam int LINE_W = 128;
    localparam int ADDR_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_RESP     = 2'd2
    } mem_state_t;

    // Strip the byte offset within a 16-byte line.
    function automatic addr_t line_addr(input addr_t a);
        return {a[ADDR_W-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/inst_bus_responder_if.sv
// Fetch-side and memory-side signals of the instruction bus responder.
// slave = the responder itself; master = fetch stage plus backing memory.
interface inst_bus_responder_if;
    import inst_bus_responder_pkg::*;

    logic  inst_req;
    addr_t inst_addr;
    logic  inst_addr_ok;
    line_t inst_rdata;
    logic  inst_data_ok;
    logic  inst_flush;
    logic  mem_en;
    addr_t mem_addr;
    line_t mem_rdata;
    logic  mem_rvalid;

    modport slave (
        input  inst_req, inst_addr, inst_flush, mem_rdata, mem_rvalid,
        output inst_addr_ok, inst_rdata, inst_data_ok, mem_en, mem_addr
    );

    modport master (
        output inst_req, inst_addr, inst_flush, mem_rdata, mem_rvalid,
        input  inst_addr_ok, inst_rdata, inst_data_ok, mem_en, mem_addr
    );

endinterface

// File: rtl/inst_bus_responder_fifo.sv
// inst_req_fifo: small address FIFO of accepted-but-unanswered line requests.
// Wrapping pointers plus an occupancy count; head is readable in the same cycle.
module inst_req_fifo
    import inst_bus_responder_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  addr_t push_addr,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output addr_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    addr_t            slot_reg [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = slot_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Slot storage needs no reset: it is only read while the count says it is live.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi)))
                    slot_reg[gi] <= push_addr;
            end
        end
    endgenerate

endmodule

// File: rtl/inst_bus_responder.sv
// Instruction fetch responder: queues line requests, reads lines one at a time
// from memory and answers in order. Optional one-line buffer: INST_RESP_LINEBUF_EN.
module inst_bus_responder
    import inst_bus_responder_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_bus_responder_if.slave  bus
);

    mem_state_t state_reg;
    mem_state_t state_next;
    logic       fifo_full;
    logic       fifo_empty;
    addr_t      fifo_head;
    logic       handshake;
    logic       hit;
    logic       hit_pending;
    logic       push;
    logic       pop;
    logic       load;
    logic       resp;
    logic       mem_en_c;
    line_t      rdata_reg;

    assign handshake = bus.inst_req && !fifo_full;
    assign push      = handshake && !hit;

    inst_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (line_addr(bus.inst_addr)),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

`ifdef INST_RESP_LINEBUF_EN
    logic                buf_valid_reg;
    logic [ADDR_W-1:4]   buf_tag_reg;
    line_t               buf_data_reg;
    logic                hit_pending_reg;

    // A hit is only safe with nothing queued ahead of it, else ordering breaks.
    assign hit = handshake && !bus.inst_flush && buf_valid_reg && fifo_empty
                 && (state_reg == ST_IDLE)
                 && (buf_tag_reg == bus.inst_addr[ADDR_W-1:4]);
    assign hit_pending = hit_pending_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_valid_reg   <= 1'b0;
            hit_pending_reg <= 1'b0;
        end else begin
            hit_pending_reg <= hit;
            if (bus.inst_flush) begin
                buf_valid_reg <= 1'b0;
            end else if (resp) begin
                buf_valid_reg <= 1'b1;
                buf_tag_reg   <= fifo_head[ADDR_W-1:4];
                buf_data_reg  <= rdata_reg;
            end
        end
    end
`else
    logic unused_flush;
    assign hit          = 1'b0;
    assign hit_pending  = 1'b0;
    assign unused_flush = bus.inst_flush;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        mem_en_c   = 1'b0;
        pop        = 1'b0;
        load       = 1'b0;
        resp       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    mem_en_c   = 1'b1;
                    state_next = ST_WAIT_MEM;
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    load       = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp       = 1'b1;
                pop        = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Response data holds until the next load so the consumer can sample late.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_reg <= '0;
        end else if (load) begin
            rdata_reg <= bus.mem_rdata;
        end
`ifdef INST_RESP_LINEBUF_EN
        else if (hit) begin
            rdata_reg <= buf_data_reg;
        end
`endif
    end

    assign bus.inst_addr_ok = !fifo_full;
    assign bus.inst_data_ok = resp || hit_pending;
    assign bus.inst_rdata   = rdata_reg;
    assign bus.mem_en       = mem_en_c;
    assign bus.mem_addr     = mem_en_c ? fifo_head : '0;

endmodule

// File: tb/tb_inst_bus_responder.sv
// Directed bench for inst_bus_responder plus a random in-order stream check.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_inst_bus_responder;
    import inst_bus_responder_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    addr_t exp_q[$];
    int    resp_cnt = 0;
    int    acc_cnt  = 0;
    bit    done     = 1'b0;

    always #5 clk = ~clk;

    inst_bus_responder_if bus_if ();

    inst_bus_responder #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    localparam line_t LA = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
    localparam line_t L1 = 128'h11111111_22222222_33333333_44444444;
    localparam line_t L2 = 128'h55555555_66666666_77777777_88888888;
    localparam line_t L3 = 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC;
    localparam line_t L4 = 128'h0BADF00D_DEADBEEF_CAFEBABE_12345678;
    localparam line_t L5 = 128'h40404040_41414141_42424242_43434343;
    localparam line_t L6 = 128'h60606060_61616161_62626262_63636363;
    localparam line_t LJ = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;

    function automatic line_t mem_line(input addr_t a);
        return {~a, a ^ 32'h3333_3333, a ^ 32'h5A5A_5A5A, a};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_if.inst_req   = 1'b0;
        bus_if.inst_addr  = '0;
        bus_if.inst_flush = 1'b0;
        bus_if.mem_rdata  = '0;
        bus_if.mem_rvalid = 1'b0;

        // Reset state
        repeat (3) cyc();
        smp();
        chk("rst_data_ok", bus_if.inst_data_ok, 1'b0);
        chk("rst_mem_en",  bus_if.mem_en, 1'b0);
        chk("rst_mem_addr", bus_if.mem_addr, 32'h0);
        chk("rst_rdata",   bus_if.inst_rdata, 128'h0);
        chk("rst_addr_ok", bus_if.inst_addr_ok, 1'b1);
        cyc(); rst = 1'b1;

        // Single miss, memory answers 2 cycles after mem_en
        bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'h1FC0_0004;
        smp(); chk("miss_addr_ok", bus_if.inst_addr_ok, 1'b1);
        cyc(); bus_if.inst_req = 1'b0;
        smp(); chk("miss_mem_en", bus_if.mem_en, 1'b1);
        chk("miss_mem_addr", bus_if.mem_addr, 32'h1FC0_0000);
        chk("miss_t1_data_ok", bus_if.inst_data_ok, 1'b0);
        cyc(); smp();
        chk("miss_t2_mem_en", bus_if.mem_en, 1'b0);
        chk("miss_t2_data_ok", bus_if.inst_data_ok, 1'b0);
        cyc(); bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = LA;
        smp(); chk("miss_t3_data_ok", bus_if.inst_data_ok, 1'b0);
        cyc(); bus_if.mem_rvalid = 1'b0; bus_if.mem_rdata = '0;
        smp(); chk("miss_t4_data_ok", bus_if.inst_data_ok, 1'b1);
        chk("miss_t4_rdata", bus_if.inst_rdata, LA);
        $display("resp addr=%h data=%h", 32'h1FC0_0000, bus_if.inst_rdata);
        cyc(); smp();
        chk("miss_t5_data_ok", bus_if.inst_data_ok, 1'b0);
        chk("miss_t5_rdata_hold", bus_if.inst_rdata, LA);

        // Back-to-back 0x100, 0x210, 0x320 with a depth-2 FIFO
        cyc(); bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'h100;
        smp(); chk("b2b_0_addr_ok", bus_if.inst_addr_ok, 1'b1);
        cyc(); bus_if.inst_addr = 32'h210;
        smp(); chk("b2b_1_addr_ok", bus_if.inst_addr_ok, 1'b1);
        chk("b2b_1_mem_en", bus_if.mem_en, 1'b1);
        chk("b2b_1_mem_addr", bus_if.mem_addr, 32'h100);
        cyc(); bus_if.inst_addr = 32'h320; bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = L1;
        smp(); chk("b2b_2_full", bus_if.inst_addr_ok, 1'b0);
        cyc(); bus_if.mem_rvalid = 1'b0;
        smp(); chk("b2b_3_data_ok", bus_if.inst_data_ok, 1'b1);
        chk("b2b_3_rdata", bus_if.inst_rdata, L1);
        chk("b2b_3_full_pop", bus_if.inst_addr_ok, 1'b0);
        $display("resp addr=%h data=%h", 32'h100, bus_if.inst_rdata);
        cyc(); smp();
        chk("b2b_4_addr_ok", bus_if.inst_addr_ok, 1'b1);
        chk("b2b_4_mem_en", bus_if.mem_en, 1'b1);
        chk("b2b_4_mem_addr", bus_if.mem_addr, 32'h210);
        cyc(); bus_if.inst_req = 1'b0; bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = L2;
        smp(); chk("b2b_5_full", bus_if.inst_addr_ok, 1'b0);
        cyc(); bus_if.mem_rvalid = 1'b0;
        smp(); chk("b2b_6_data_ok", bus_if.inst_data_ok, 1'b1);
        chk("b2b_6_rdata", bus_if.inst_rdata, L2);
        $display("resp addr=%h data=%h", 32'h210, bus_if.inst_rdata);
        cyc(); smp();
        chk("b2b_7_mem_en", bus_if.mem_en, 1'b1);
        chk("b2b_7_mem_addr", bus_if.mem_addr, 32'h320);
        cyc(); bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = L3;
        smp(); chk("b2b_8_data_ok", bus_if.inst_data_ok, 1'b0);
        cyc(); bus_if.mem_rvalid = 1'b0;
        smp(); chk("b2b_9_data_ok", bus_if.inst_data_ok, 1'b1);
        chk("b2b_9_rdata", bus_if.inst_rdata, L3);
        $display("resp addr=%h data=%h", 32'h320, bus_if.inst_rdata);
        cyc(); smp();
        chk("b2b_10_data_ok", bus_if.inst_data_ok, 1'b0);
        chk("b2b_10_mem_en", bus_if.mem_en, 1'b0);

        // Spurious mem_rvalid while idle
        cyc(); bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = LJ;
        smp(); chk("spur_data_ok", bus_if.inst_data_ok, 1'b0);
        chk("spur_mem_en", bus_if.mem_en, 1'b0);
        cyc(); bus_if.mem_rvalid = 1'b0;
        smp(); chk("spur_next_data_ok", bus_if.inst_data_ok, 1'b0);
        chk("spur_rdata_hold", bus_if.inst_rdata, L3);
        cyc(); bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'h500;
        cyc(); bus_if.inst_req = 1'b0;
        smp(); chk("spur_after_mem_en", bus_if.mem_en, 1'b1);
        chk("spur_after_mem_addr", bus_if.mem_addr, 32'h500);
        cyc(); bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = L4;
        cyc(); bus_if.mem_rvalid = 1'b0;
        smp(); chk("spur_after_data_ok", bus_if.inst_data_ok, 1'b1);
        chk("spur_after_rdata", bus_if.inst_rdata, L4);
        $display("resp addr=%h data=%h", 32'h500, bus_if.inst_rdata);

        // Reset asserted while waiting on memory
        cyc(); bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'h600;
        cyc(); bus_if.inst_req = 1'b0;
        smp(); chk("rstmid_mem_en", bus_if.mem_en, 1'b1);
        cyc(); rst = 1'b0;
        smp(); chk("rstmid_wait_data_ok", bus_if.inst_data_ok, 1'b0);
        cyc(); rst = 1'b1; bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = LJ;
        smp(); chk("rstmid_data_ok", bus_if.inst_data_ok, 1'b0);
        chk("rstmid_mem_en_0", bus_if.mem_en, 1'b0);
        chk("rstmid_addr_ok", bus_if.inst_addr_ok, 1'b1);
        chk("rstmid_rdata", bus_if.inst_rdata, 128'h0);
        cyc(); bus_if.mem_rvalid = 1'b0;
        smp(); chk("rstmid_late_data_ok", bus_if.inst_data_ok, 1'b0);
        chk("rstmid_late_mem_en", bus_if.mem_en, 1'b0);
        chk("rstmid_late_rdata", bus_if.inst_rdata, 128'h0);
        cyc(); smp(); chk("rstmid_later_data_ok", bus_if.inst_data_ok, 1'b0);

        // Same-line repeat: buffered hit when enabled, ordinary miss otherwise
        cyc(); bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'h40;
        cyc(); bus_if.inst_req = 1'b0;
        smp(); chk("lb_miss_mem_en", bus_if.mem_en, 1'b1);
        chk("lb_miss_mem_addr", bus_if.mem_addr, 32'h40);
        cyc(); bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = L5;
        cyc(); bus_if.mem_rvalid = 1'b0;
        smp(); chk("lb_miss_data_ok", bus_if.inst_data_ok, 1'b1);
        chk("lb_miss_rdata", bus_if.inst_rdata, L5);
        $display("resp addr=%h data=%h", 32'h40, bus_if.inst_rdata);
        cyc(); bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'h48;
        smp(); chk("lb_req2_addr_ok", bus_if.inst_addr_ok, 1'b1);
        chk("lb_req2_mem_en", bus_if.mem_en, 1'b0);
        cyc(); bus_if.inst_req = 1'b0;
`ifdef INST_RESP_LINEBUF_EN
        smp(); chk("lb_hit_data_ok", bus_if.inst_data_ok, 1'b1);
        chk("lb_hit_rdata", bus_if.inst_rdata, L5);
        chk("lb_hit_no_mem_en", bus_if.mem_en, 1'b0);
        $display("resp addr=%h data=%h (buffered)", 32'h48, bus_if.inst_rdata);
        cyc(); bus_if.inst_flush = 1'b1;
        smp(); chk("lb_flush_data_ok", bus_if.inst_data_ok, 1'b0);
        chk("lb_flush_mem_en", bus_if.mem_en, 1'b0);
        cyc(); bus_if.inst_flush = 1'b0; bus_if.inst_req = 1'b1; bus_if.inst_addr = 32'h4C;
        cyc(); bus_if.inst_req = 1'b0;
        smp(); chk("lb_flushed_mem_en", bus_if.mem_en, 1'b1);
        chk("lb_flushed_mem_addr", bus_if.mem_addr, 32'h40);
        chk("lb_flushed_data_ok", bus_if.inst_data_ok, 1'b0);
`else
        smp(); chk("nolb_req2_mem_en", bus_if.mem_en, 1'b1);
        chk("nolb_req2_mem_addr", bus_if.mem_addr, 32'h40);
        chk("nolb_req2_data_ok", bus_if.inst_data_ok, 1'b0);
`endif
        cyc(); bus_if.mem_rvalid = 1'b1; bus_if.mem_rdata = L6;
        cyc(); bus_if.mem_rvalid = 1'b0;
        smp(); chk("lb_second_data_ok", bus_if.inst_data_ok, 1'b1);
        chk("lb_second_rdata", bus_if.inst_rdata, L6);
        $display("resp addr=%h data=%h", 32'h40, bus_if.inst_rdata);
        cyc(); smp(); chk("lb_idle_data_ok", bus_if.inst_data_ok, 1'b0);

        // Random stream: 1000 accepted requests, random memory latency
        fork
            begin : driver
                int cycles = 0;
                while (acc_cnt < 1000 && cycles < 30000) begin
                    cyc();
                    bus_if.inst_req  = 1'b1 & 1'($urandom_range(0, 1));
                    bus_if.inst_addr = 32'h1000 + (32'($urandom_range(0, 7)) << 4)
                                       + (32'($urandom_range(0, 3)) << 2);
                    smp();
                    if (bus_if.inst_req && bus_if.inst_addr_ok) begin
                        exp_q.push_back(line_addr(bus_if.inst_addr));
                        acc_cnt++;
                    end
                    cycles++;
                end
                cyc(); bus_if.inst_req = 1'b0;
                for (int i = 0; i < 200; i++) begin
                    if (resp_cnt == acc_cnt) break;
                    smp();
                end
                chk("rand_accept_count", 128'(acc_cnt), 128'(1000));
                chk("rand_resp_count", 128'(resp_cnt), 128'(acc_cnt));
                $display("random stream: %0d accepted, %0d responses", acc_cnt, resp_cnt);
                done = 1'b1;
            end
            begin : memory
                while (!done) begin
                    smp();
                    if (bus_if.mem_en) begin
                        addr_t a;
                        int lat;
                        a   = bus_if.mem_addr;
                        lat = $urandom_range(1, 4);
                        repeat (lat) cyc();
                        bus_if.mem_rvalid = 1'b1;
                        bus_if.mem_rdata  = mem_line(a);
                        cyc();
                        bus_if.mem_rvalid = 1'b0;
                        bus_if.mem_rdata  = '0;
                    end
                end
            end
            begin : monitor
                while (!done) begin
                    smp();
                    if (bus_if.inst_data_ok) begin
                        if (exp_q.size() == 0) begin
                            chk("rand_unexpected_resp", 128'(1), 128'(0));
                        end else begin
                            addr_t e;
                            e = exp_q.pop_front();
                            chk("rand_data", bus_if.inst_rdata, mem_line(e));
                        end
                        resp_cnt++;
                    end
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
